// File: rtl/hazard_pipectrl.sv
// hazard_pipectrl
//
// Pipeline stall/flush controller for the five-stage RV32 core. It drives
// per-stage hold and bubble controls for the PC, IF, ID, EXE and MEM stage
// registers. It handles:
//   - variable-latency data memory (MEM_WAIT freezes the whole pipe),
//   - multi-cycle EXE operations (MC_BUSY freezes PC..EXE and bubbles MEM),
//   - taken jumps/branches, with a pending-jump register so a redirect
//     raised while the pipe is frozen is replayed once it runs again,
//   - load-use hazards and instruction-fetch wait.
//
// Parameters:
//   XLEN    width of the jump target path
//   LAT_W   width of the multi-cycle latency field
//   PERF_W  width of each performance counter
//
// Ports:
//   clk_i             core clock
//   rst_i             synchronous, active-high reset
//   loaduse_hazard_i  ID consumer depends on the EXE load
//   je_i, jump_addr_i taken jump/branch resolved in EXE and its target
//   imem_ready_i      fetch data valid this cycle
//   dmem_req_i        MEM stage has a load/store in flight
//   dmem_ready_i      data memory completes this cycle
//   mc_start_i        EXE issues a multi-cycle operation
//   mc_lat_i          extra busy cycles for that operation
//   je_o, jump_addr_o PC redirect and its target (target is 0 when je_o=0)
//   stall_o[4:0]      per-stage hold: bit0 PC, 1 IF, 2 ID, 3 EXE, 4 MEM
//   flush_o[4:0]      per-stage bubble load, same bit order
//   perf_stall_cnt_o  cycles with stall_o[0]=1 (saturating)
//   perf_flush_cnt_o  count of je_o pulses (saturating)
//
// Build option:
//   HAZARD_PERFCNT_EN  when defined, the two performance counters are
//                      implemented; otherwise the ports read constant 0.
//
// State table:
//   ST_RUN      | pipeline running; jumps, load-use and fetch wait handled
//   ST_MEM_WAIT | data memory outstanding; whole pipe held
//   ST_MC_BUSY  | multi-cycle EXE op counting down; PC..EXE held, MEM bubbled

module hazard_pipectrl #(
  parameter int XLEN   = 32,
  parameter int LAT_W  = 4,
  parameter int PERF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              loaduse_hazard_i,
  input  logic              je_i,
  input  logic [XLEN-1:0]   jump_addr_i,
  input  logic              imem_ready_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ready_i,
  input  logic              mc_start_i,
  input  logic [LAT_W-1:0]  mc_lat_i,
  output logic              je_o,
  output logic [XLEN-1:0]   jump_addr_o,
  output logic [4:0]        stall_o,
  output logic [4:0]        flush_o,
  output logic [PERF_W-1:0] perf_stall_cnt_o,
  output logic [PERF_W-1:0] perf_flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MC_BUSY  = 2'd2
  } state_t;

  localparam logic [LAT_W-1:0] CNT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d, eff_state;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
  logic              mem_wait;
  logic              frozen;

  assign mem_wait = dmem_req_i & ~dmem_ready_i;

  // In the cycle data memory completes, the controller already behaves as
  // the state it is returning to (RUN, or MC_BUSY if an op was interrupted),
  // so the release has zero-cycle latency from dmem_ready_i.
  always_comb begin
    eff_state = state_q;
    if (state_q == ST_MEM_WAIT && !mem_wait) begin
      eff_state = (cnt_q != '0) ? ST_MC_BUSY : ST_RUN;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    stall_o     = 5'b00000;
    flush_o     = 5'b00000;
    je_o        = 1'b0;
    jump_addr_o = '0;
    frozen      = 1'b0;

    if (mem_wait) begin
      // Counter deliberately held so an interrupted MC op resumes intact.
      state_d = ST_MEM_WAIT;
      stall_o = 5'b11111;
      frozen  = 1'b1;
    end else if (eff_state == ST_MC_BUSY) begin
      stall_o = 5'b01111;
      flush_o = 5'b10000;
      frozen  = 1'b1;
      if (cnt_q <= CNT_ONE) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        state_d = ST_MC_BUSY;
        cnt_d   = cnt_q - CNT_ONE;
      end
    end else begin
      state_d = ST_RUN;
      if (mc_start_i && mc_lat_i != '0) begin
        // Entry cycle counts as the first frozen cycle.
        state_d = ST_MC_BUSY;
        cnt_d   = mc_lat_i;
        stall_o = 5'b01111;
        flush_o = 5'b10000;
        frozen  = 1'b1;
      end else if (pend_q) begin
        // The held EXE instruction still shows je_i; it is the same jump,
        // so only the stored target is issued.
        je_o        = 1'b1;
        jump_addr_o = pend_addr_q;
        flush_o     = 5'b00110;
        pend_d      = 1'b0;
      end else if (je_i) begin
        je_o        = 1'b1;
        jump_addr_o = jump_addr_i;
        flush_o     = 5'b00110;
      end else if (loaduse_hazard_i) begin
        stall_o = 5'b00111;
        flush_o = 5'b01000;
      end else if (!imem_ready_i) begin
        stall_o = 5'b00001;
        flush_o = 5'b00010;
      end
    end

    // A redirect raised while the pipe is frozen is remembered; the first
    // one wins until it has been issued.
    if (frozen && je_i && !pend_q) begin
      pend_d      = 1'b1;
      pend_addr_d = jump_addr_i;
    end

    if (rst_i) begin
      stall_o     = 5'b00000;
      flush_o     = 5'b11110;
      je_o        = 1'b0;
      jump_addr_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

`ifdef HAZARD_PERFCNT_EN
  logic [PERF_W-1:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_o[0] && perf_stall_q != '1) begin
        perf_stall_q <= perf_stall_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end
      if (je_o && perf_flush_q != '1) begin
        perf_flush_q <= perf_flush_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_pipectrl.sv
// Directed testbench for hazard_pipectrl. Inputs change 1 time unit after
// a rising edge; combinational outputs are checked 1 unit later.
module tb_hazard_pipectrl;

  localparam int XLEN   = 32;
  localparam int LAT_W  = 4;
  localparam int PERF_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              loaduse_hazard_i;
  logic              je_i;
  logic [XLEN-1:0]   jump_addr_i;
  logic              imem_ready_i;
  logic              dmem_req_i;
  logic              dmem_ready_i;
  logic              mc_start_i;
  logic [LAT_W-1:0]  mc_lat_i;
  logic              je_o;
  logic [XLEN-1:0]   jump_addr_o;
  logic [4:0]        stall_o;
  logic [4:0]        flush_o;
  logic [PERF_W-1:0] perf_stall_cnt_o;
  logic [PERF_W-1:0] perf_flush_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_pipectrl #(.XLEN(XLEN), .LAT_W(LAT_W), .PERF_W(PERF_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .loaduse_hazard_i (loaduse_hazard_i),
    .je_i             (je_i),
    .jump_addr_i      (jump_addr_i),
    .imem_ready_i     (imem_ready_i),
    .dmem_req_i       (dmem_req_i),
    .dmem_ready_i     (dmem_ready_i),
    .mc_start_i       (mc_start_i),
    .mc_lat_i         (mc_lat_i),
    .je_o             (je_o),
    .jump_addr_o      (jump_addr_o),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_flush_cnt_o (perf_flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    loaduse_hazard_i = 1'b0;
    je_i             = 1'b0;
    jump_addr_i      = '0;
    imem_ready_i     = 1'b1;
    dmem_req_i       = 1'b0;
    dmem_ready_i     = 1'b0;
    mc_start_i       = 1'b0;
    mc_lat_i         = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    je_i = 1'b1; jump_addr_i = 32'hDEAD_BEEF; loaduse_hazard_i = 1'b1; imem_ready_i = 1'b0;
    tick(); tick();
    #1;
    n_checks++;
    if (flush_o !== 5'b11110) begin n_fail++; $display("FAIL reset_flush: got %b want 11110", flush_o); end
    n_checks++;
    if (stall_o !== 5'b00000) begin n_fail++; $display("FAIL reset_stall: got %b want 00000", stall_o); end
    n_checks++;
    if (je_o !== 1'b0 || jump_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_je: got %b/%h want 0/0", je_o, jump_addr_o); end
    tick();
    rst_i = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if (stall_o !== 5'b0 || flush_o !== 5'b0 || je_o !== 1'b0)
      begin n_fail++; $display("FAIL idle: got stall %b flush %b je %b want 0 0 0", stall_o, flush_o, je_o); end
    n_checks++;
    if (perf_stall_cnt_o !== '0 || perf_flush_cnt_o !== '0)
      begin n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_stall_cnt_o, perf_flush_cnt_o); end
    tick();
  endtask

  task automatic test_jump_loaduse();
    je_i = 1'b1; jump_addr_i = 32'h0000_0100; loaduse_hazard_i = 1'b1;
    #1;
    n_checks++;
    if (je_o !== 1'b1 || jump_addr_o !== 32'h100) begin n_fail++; $display("FAIL jump_je: got %b/%h want 1/00000100", je_o, jump_addr_o); end
    n_checks++;
    if (flush_o !== 5'b00110 || stall_o !== 5'b00000) begin n_fail++; $display("FAIL jump_ctl: got stall %b flush %b want 00000 00110", stall_o, flush_o); end
    tick();
    je_i = 1'b0; jump_addr_i = 32'h0000_0104;
    #1;
    n_checks++;
    if (stall_o !== 5'b00111 || flush_o !== 5'b01000 || je_o !== 1'b0 || jump_addr_o !== 32'h0)
      begin n_fail++; $display("FAIL loaduse: got stall %b flush %b je %b addr %h want 00111 01000 0 0", stall_o, flush_o, je_o, jump_addr_o); end
    tick();
    loaduse_hazard_i = 1'b0; imem_ready_i = 1'b0;
    #1;
    n_checks++;
    if (stall_o !== 5'b00001 || flush_o !== 5'b00010 || je_o !== 1'b0)
      begin n_fail++; $display("FAIL imem_wait: got stall %b flush %b je %b want 00001 00010 0", stall_o, flush_o, je_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_mc();
    mc_start_i = 1'b1; mc_lat_i = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (stall_o !== 5'b01111 || flush_o !== 5'b10000)
        begin n_fail++; $display("FAIL mc_busy cyc%0d: got stall %b flush %b want 01111 10000", i, stall_o, flush_o); end
      tick();
      mc_start_i = 1'b0; mc_lat_i = '0;
    end
    #1;
    n_checks++;
    if (stall_o !== 5'b0 || flush_o !== 5'b0) begin n_fail++; $display("FAIL mc_end: got stall %b flush %b want 0 0", stall_o, flush_o); end
    tick();
    mc_start_i = 1'b1; mc_lat_i = 4'd0;
    #1;
    n_checks++;
    if (stall_o !== 5'b0 || flush_o !== 5'b0) begin n_fail++; $display("FAIL mc_lat0: got stall %b flush %b want 0 0", stall_o, flush_o); end
    tick();
    mc_start_i = 1'b0;
    #1;
    n_checks++;
    if (stall_o !== 5'b0 || flush_o !== 5'b0) begin n_fail++; $display("FAIL mc_lat0_next: got stall %b flush %b want 0 0", stall_o, flush_o); end
    tick();
  endtask

  task automatic test_mem_wait_jump();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      je_i = 1'b0; jump_addr_i = '0;
      if (i == 1) begin je_i = 1'b1; jump_addr_i = 32'h0000_0200; end
      if (i == 3) begin je_i = 1'b1; jump_addr_i = 32'h0000_0300; end
      #1;
      n_checks++;
      if (stall_o !== 5'b11111 || flush_o !== 5'b0 || je_o !== 1'b0)
        begin n_fail++; $display("FAIL memwait cyc%0d: got stall %b flush %b je %b want 11111 0 0", i, stall_o, flush_o, je_o); end
      tick();
    end
    dmem_ready_i = 1'b1; je_i = 1'b1; jump_addr_i = 32'h0000_0400;
    #1;
    n_checks++;
    if (je_o !== 1'b1 || jump_addr_o !== 32'h200) begin n_fail++; $display("FAIL pend_issue: got %b/%h want 1/00000200", je_o, jump_addr_o); end
    n_checks++;
    if (stall_o !== 5'b0 || flush_o !== 5'b00110) begin n_fail++; $display("FAIL pend_ctl: got stall %b flush %b want 0 00110", stall_o, flush_o); end
    tick();
    dmem_req_i = 1'b0; dmem_ready_i = 1'b0; je_i = 1'b0; jump_addr_i = '0;
    #1;
    n_checks++;
    if (je_o !== 1'b0 || flush_o !== 5'b0) begin n_fail++; $display("FAIL pend_once: got je %b flush %b want 0 0", je_o, flush_o); end
    tick();
  endtask

  task automatic test_mc_mem_interrupt();
    mc_start_i = 1'b1; mc_lat_i = 4'd2;
    #1;
    n_checks++;
    if (stall_o !== 5'b01111) begin n_fail++; $display("FAIL mcint_entry: got %b want 01111", stall_o); end
    tick();
    mc_start_i = 1'b0; mc_lat_i = '0;
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (stall_o !== 5'b11111 || flush_o !== 5'b0)
        begin n_fail++; $display("FAIL mcint_wait cyc%0d: got stall %b flush %b want 11111 0", i, stall_o, flush_o); end
      tick();
    end
    dmem_req_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (stall_o !== 5'b01111 || flush_o !== 5'b10000)
        begin n_fail++; $display("FAIL mcint_resume cyc%0d: got stall %b flush %b want 01111 10000", i, stall_o, flush_o); end
      tick();
    end
    #1;
    n_checks++;
    if (stall_o !== 5'b0 || flush_o !== 5'b0) begin n_fail++; $display("FAIL mcint_end: got stall %b flush %b want 0 0", stall_o, flush_o); end
    tick();
  endtask

  task automatic test_mc_jump_pending();
    mc_start_i = 1'b1; mc_lat_i = 4'd1;
    tick();
    mc_start_i = 1'b0; mc_lat_i = '0;
    je_i = 1'b1; jump_addr_i = 32'h0000_0500;
    #1;
    n_checks++;
    if (stall_o !== 5'b01111 || je_o !== 1'b0) begin n_fail++; $display("FAIL mcjump_busy: got stall %b je %b want 01111 0", stall_o, je_o); end
    tick();
    #1;
    n_checks++;
    if (je_o !== 1'b1 || jump_addr_o !== 32'h500 || flush_o !== 5'b00110)
      begin n_fail++; $display("FAIL mcjump_issue: got je %b addr %h flush %b want 1 00000500 00110", je_o, jump_addr_o, flush_o); end
    tick();
    je_i = 1'b0; jump_addr_i = '0;
    #1;
    n_checks++;
    if (je_o !== 1'b0 || stall_o !== 5'b0) begin n_fail++; $display("FAIL mcjump_after: got je %b stall %b want 0 0", je_o, stall_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    mc_start_i = 1'b1; mc_lat_i = 4'd5;
    tick();
    mc_start_i = 1'b0; mc_lat_i = '0;
    je_i = 1'b1; jump_addr_i = 32'h0000_0600;
    tick();
    je_i = 1'b0; jump_addr_i = '0;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (stall_o !== 5'b0 || flush_o !== 5'b11110) begin n_fail++; $display("FAIL rstmid_forced: got stall %b flush %b want 0 11110", stall_o, flush_o); end
    tick();
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (stall_o !== 5'b0 || flush_o !== 5'b0 || je_o !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_clear: got stall %b flush %b je %b want 0 0 0", stall_o, flush_o, je_o); end
    tick();
  endtask

  task automatic test_perf();
    logic [PERF_W-1:0] exp10, exp20, expj;
`ifdef HAZARD_PERFCNT_EN
    exp10 = 4'd10; exp20 = 4'd15; expj = 4'd2;
`else
    exp10 = 4'd0; exp20 = 4'd0; expj = 4'd0;
`endif
    do_reset();
    imem_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (perf_stall_cnt_o !== exp10) begin n_fail++; $display("FAIL perf_stall10: got %0d want %0d", perf_stall_cnt_o, exp10); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (perf_stall_cnt_o !== exp20) begin n_fail++; $display("FAIL perf_stall20: got %0d want %0d", perf_stall_cnt_o, exp20); end
    imem_ready_i = 1'b1;
    je_i = 1'b1; jump_addr_i = 32'h0000_0700;
    tick(); tick();
    je_i = 1'b0;
    tick();
    n_checks++;
    if (perf_flush_cnt_o !== expj) begin n_fail++; $display("FAIL perf_flush: got %0d want %0d", perf_flush_cnt_o, expj); end
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_jump_loaduse();
    test_mc();
    test_mem_wait_jump();
    test_mc_mem_interrupt();
    test_mc_jump_pending();
    test_reset_mid();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_pipectrl.md
# hazard_pipectrl

Parametrised pipeline controller for the five-stage RV32 core, a successor to the combinational stall/flush unit. It adds variable-latency handshakes for instruction and data memory, a multi-cycle EXE operation sequencer, and a pending-jump register so redirects are never lost while the back end is frozen. It sits beside the PC, IF, ID, EXE and MEM stage registers in the core top and drives their per-stage stall and flush controls.

## Interface
- XLEN, 32: address/data width of the jump path.
- LAT_W, 4: width of the multi-cycle latency field (max 2^LAT_W-1 busy cycles).
- PERF_W, 16: width of each performance counter.

- clk_i  in  1  core clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- loaduse_hazard_i  in  1  ID consumer depends on the EXE load.
- je_i  in  1  EXE resolved a taken jump or branch.
- jump_addr_i  in  XLEN  target for je_i.
- imem_ready_i  in  1  fetch data is valid this cycle.
- dmem_req_i  in  1  MEM stage has a load or store in flight.
- dmem_ready_i  in  1  data memory completes this cycle.
- mc_start_i  in  1  EXE is issuing a multi-cycle operation.
- mc_lat_i  in  LAT_W  extra busy cycles for that operation.
- je_o  out  1  redirect the PC.
- jump_addr_o  out  XLEN  redirect target.
- stall_o  out  5  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EXE, bit4 MEM.
- flush_o  out  5  per-stage bubble load, same bit order.
- perf_stall_cnt_o  out  PERF_W  cycles with stall_o[0]=1.
- perf_flush_cnt_o  out  PERF_W  count of je_o pulses.

## Operation
- States: RUN, MEM_WAIT, MC_BUSY. Registers: state, busy counter (LAT_W), pending-jump valid flag plus address.
- Per-cycle priority: MEM_WAIT > MC_BUSY > jump > load-use > imem wait.
- MEM_WAIT
  - Entered or held when dmem_req_i=1 and dmem_ready_i=0, from any state.
  - stall_o=5'b11111, flush_o=0.
  - Leave in the cycle dmem_ready_i=1: go to MC_BUSY if the counter is non-zero, else RUN.
  - The MC_BUSY counter does not decrement while in MEM_WAIT.
- MC_BUSY
  - Entered from RUN when mc_start_i=1 and mc_lat_i!=0. The counter loads mc_lat_i.
  - In the entry cycle and every busy cycle: stall_o=5'b01111, flush_o=5'b10000 (bubble into MEM).
  - The counter decrements each MC_BUSY cycle. Return to RUN when the counter goes 1→0.
  - mc_lat_i=0 means single-cycle: no state change.
- Jump
  - In RUN with no pending jump and je_i=1: je_o=1, jump_addr_o=jump_addr_i, flush_o[1]=flush_o[2]=1.
  - Overrides load-use and imem wait in the same cycle.
  - je_i=1 while in MEM_WAIT or MC_BUSY with pending clear: capture jump_addr_i and set pending. Further je_i is ignored while pending is set.
  - First RUN cycle with pending set: je_o=1 from the pending address, IF/ID flushed, pending cleared. je_i is ignored that cycle (it is the same held instruction).
- Load-use (RUN, no jump): stall_o=5'b00111, flush_o=5'b01000.
- Imem wait (RUN, imem_ready_i=0, nothing above active): stall_o[0]=1, flush_o[1]=1. All other bits are 0.
- Otherwise: stall_o=0, flush_o=0, je_o=0.
- jump_addr_o=0 whenever je_o=0.

## Timing
- Reset (rst_i=1 at the edge): state=RUN, counter=0, pending=0, perf counters=0.
- While rst_i=1, outputs are forced: stall_o=0, flush_o=5'b11110, je_o=0, jump_addr_o=0.
- All outputs are combinational from the registered state plus the current inputs. Zero-cycle latency from je_i, loaduse_hazard_i, imem_ready_i, dmem_ready_i.
- An MC operation with mc_lat_i=N freezes stages 0-3 for exactly N+1 cycles: the entry cycle plus N busy cycles.
- Asserting rst_i mid-MC_BUSY or mid-MEM_WAIT discards the counter and any pending jump.

## Configuration
- HAZARD_PERFCNT_EN defined: both perf counters increment per Interface definitions and saturate at all-ones. Reset clears them.
- HAZARD_PERFCNT_EN undefined: ports remain, driven constant 0. No counter flops are synthesised.

## Test plan
- Reset, then idle with imem_ready_i=1: stall_o=0, flush_o=0, je_o=0. Under rst_i, flush_o=5'b11110.
- je_i=1, jump_addr_i=0x0000_0100 together with loaduse_hazard_i=1 in RUN → same cycle je_o=1, jump_addr_o=0x100, flush_o=5'b00110, stall_o=0.
- mc_start_i=1, mc_lat_i=3 → stall_o=5'b01111 and flush_o=5'b10000 for exactly 4 cycles, then 0.
- dmem_req_i=1, dmem_ready_i=0 for 5 cycles with je_i=1, target 0x200, in cycle 2 → stall_o=5'b11111 for 5 cycles, je_o=0 throughout. Then in the first RUN cycle je_o=1, jump_addr_o=0x200, one pulse only.
- MC_BUSY (mc_lat_i=2) interrupted by 3 MEM_WAIT cycles → MC resumes and ends after exactly 2 more busy cycles.
- HAZARD_PERFCNT_EN with PERF_W=4: 20 stall cycles → perf_stall_cnt_o=15 (saturated). Without the macro, both counters read 0.
